// File: rtl/mult_seq_unit.sv
// Sequential shift-add multiplier (mult/multu) for the EX stage; one step per RUN cycle.
// Define MULT_SIGNED_EN to honor is_signed (magnitude conversion + final negation).
//
// state | meaning
// IDLE  | waiting for start; prod holds last result
// RUN   | one shift-add step per cycle, WIDTH steps total
// DONE  | done pulse, prod valid; start here launches the next op
module mult_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      CNT_TC  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               unused_acc_lsb;

  assign accept = start & (state_q != S_RUN);

  // The carry out of the (WIDTH+1)-bit add lands in the accumulator MSB after the shift.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign acc_step = {sum, acc_q[WIDTH-1:1]};
  assign unused_acc_lsb = acc_q[0];

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Most-negative operand maps to itself, which is its correct unsigned magnitude.
  assign a_mag    = (is_signed & a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign b_mag    = (is_signed & b[WIDTH-1]) ? (~b + ONE_W) : b;
  assign neg_d    = accept ? (is_signed & (a[WIDTH-1] ^ b[WIDTH-1])) : neg_q;
  assign prod_res = neg_q ? (~acc_step + ONE_2W) : acc_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= neg_d;
  end
`else
  logic unused_is_signed;
  logic [2*WIDTH-1:0] unused_one_2w;
  logic [WIDTH-1:0]   unused_one_w;

  assign unused_is_signed = is_signed;
  assign unused_one_2w    = ONE_2W;
  assign unused_one_w     = ONE_W;
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_res = acc_step;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_TC) begin
          state_d = S_DONE;
          prod_d  = prod_res;
          done_d  = 1'b1;
        end
      end
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = (state_q == S_RUN) | accept;
  assign done  = done_q;
  assign prod  = prod_q;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed self-checking bench for mult_seq_unit (WIDTH=32).
// Expected signed results follow MULT_SIGNED_EN the same way the design build does.
module tb_mult_seq_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a, b;
  logic           busy, stall, done;
  logic [2*W-1:0] prod;

  int checks   = 0;
  int failures = 0;

  mult_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .prod(prod)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one start pulse; returns stall seen in the accepting cycle.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s,
                        output logic acc_stall);
    a = ia; b = ib; is_signed = s; start = 1'b1;
    #1;
    acc_stall = stall;
    step();
    start = 1'b0;
    #1;
  endtask

  // Called right after the accepting edge; counts edges until done (bounded).
  task automatic wait_done(output int n, output int bc, output int sc);
    n  = 0;
    bc = busy  ? 1 : 0;
    sc = stall ? 1 : 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (!done) begin
        if (busy)  bc++;
        if (stall) sc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (prod !== 64'h0) begin failures++; $display("FAIL reset_prod got=%h exp=0", prod); end
    start = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_start got=%b exp=1", stall); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored got=%b exp=0", busy); end
    start = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned_small();
    logic s0; int n, bc, sc;
    launch(32'd3, 32'd5, 1'b0, s0);
    wait_done(n, bc, sc);
    checks++; if (s0 !== 1'b1) begin failures++; $display("FAIL small_accept_stall got=%b exp=1", s0); end
    checks++; if (n !== 32) begin failures++; $display("FAIL small_latency got=%0d exp=32", n); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL small_busy_cycles got=%0d exp=32", bc); end
    checks++; if (prod !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL small_prod got=%h exp=f", prod); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL small_busy_at_done got=%b exp=0", busy); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL small_done_width got=%b exp=0", done); end
    step();
    checks++; if (prod !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL small_prod_hold got=%h exp=f", prod); end
  endtask

  task automatic test_unsigned_max();
    logic s0; int n, bc, sc;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s0);
    wait_done(n, bc, sc);
    checks++; if (sc !== 32) begin failures++; $display("FAIL max_stall_cycles got=%0d exp=32", sc); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL max_stall_at_done got=%b exp=0", stall); end
    checks++; if (prod !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL max_prod got=%h exp=fffffffe00000001", prod); end
    step();
  endtask

  task automatic test_signed();
    logic s0; int n, bc, sc;
    logic [2*W-1:0] e1, e2, e3;
`ifdef MULT_SIGNED_EN
    e1 = 64'hFFFF_FFFF_FFFF_FFFA;
    e2 = 64'hFFFF_FFFF_0000_0000;
    e3 = 64'h0000_0000_0000_000F;
`else
    e1 = 64'h0000_0002_FFFF_FFFA;
    e2 = 64'h0000_0001_0000_0000;
    e3 = 64'hFFFF_FFF8_0000_000F;
`endif
    launch(32'hFFFF_FFFE, 32'd3, 1'b1, s0);
    wait_done(n, bc, sc);
    checks++; if (prod !== e1) begin failures++; $display("FAIL signed_neg_pos got=%h exp=%h", prod, e1); end
    step();
    launch(32'h8000_0000, 32'd2, 1'b1, s0);
    wait_done(n, bc, sc);
    checks++; if (prod !== e2) begin failures++; $display("FAIL signed_most_neg got=%h exp=%h", prod, e2); end
    step();
    launch(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, s0);
    wait_done(n, bc, sc);
    checks++; if (prod !== e3) begin failures++; $display("FAIL signed_neg_neg got=%h exp=%h", prod, e3); end
    step();
  endtask

  task automatic test_restart_ignored();
    logic s0; int n, dcnt;
    launch(32'd3, 32'd5, 1'b0, s0);
    n = 0;
    while (!done && n < 40) begin
      if (n == 9) begin a = 32'd7; b = 32'd7; start = 1'b1; end
      else start = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 32) begin failures++; $display("FAIL restart_latency got=%0d exp=32", n); end
    checks++; if (prod !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL restart_prod got=%h exp=f", prod); end
    dcnt = 0;
    repeat (40) begin
      step();
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL restart_extra_done got=%0d exp=0", dcnt); end
  endtask

  task automatic test_reset_mid_run();
    logic s0; int n, bc, sc;
    launch(32'd9, 32'd9, 1'b0, s0);
    repeat (10) step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (prod !== 64'h0) begin failures++; $display("FAIL midrst_prod got=%h exp=0", prod); end
    a = 32'd2; b = 32'd2; start = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_start_in_reset busy=%b done=%b exp=0,0", busy, done); end
    rst = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_accept_after_release got=%b exp=1", busy); end
    wait_done(n, bc, sc);
    checks++; if (n !== 32) begin failures++; $display("FAIL midrst_latency got=%0d exp=32", n); end
    checks++; if (prod !== 64'd4) begin failures++; $display("FAIL midrst_prod_after got=%h exp=4", prod); end
    step();
  endtask

  task automatic test_back_to_back();
    logic s0; int n, bc, sc;
    launch(32'd3, 32'd5, 1'b0, s0);
    wait_done(n, bc, sc);
    a = 32'd6; b = 32'd7; start = 1'b1;
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    checks++; if (prod !== 64'h0F) begin failures++; $display("FAIL b2b_first_prod got=%h exp=f", prod); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall_in_done got=%b exp=1", stall); end
    step();
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_rerun busy=%b done=%b exp=1,0", busy, done); end
    wait_done(n, bc, sc);
    checks++; if (n !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", n); end
    checks++; if (prod !== 64'h2A) begin failures++; $display("FAIL b2b_second_prod got=%h exp=2a", prod); end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_unsigned_max();
    test_signed();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
